// File: rtl/fetch_pc_predictor.sv
// Fetch-stage PC register with a direct-mapped BTB and 2-bit saturating predictor.
// Drives PC, PC+4 and a taken prediction; trained and redirected from EX/MEM.
module fetch_pc_predictor #(
    parameter int          BTB_BITS = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCWrite,
    input  logic        EM_redirect,
    input  logic [31:0] EM_target,
    input  logic        EM_update,
    input  logic [31:0] EM_PC,
    input  logic        EM_taken,
    input  logic [31:0] EM_branch_target,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        branch_taken
);

    localparam int ENTRIES = 1 << BTB_BITS;
    localparam int TAG_W   = 30 - BTB_BITS;

    logic [ENTRIES-1:0] valid_r;
    logic [TAG_W-1:0]   tag_r    [ENTRIES];
    logic [31:0]        target_r [ENTRIES];
    logic [1:0]         ctr_r    [ENTRIES];

    logic [BTB_BITS-1:0] idx_s;
    logic [TAG_W-1:0]    tag_s;
    logic                hit_s;
    logic [BTB_BITS-1:0] upd_idx_s;
    logic [TAG_W-1:0]    upd_tag_s;
    logic                upd_hit_s;
    logic [31:0]         next_pc_s;
    logic                unused_bits_s;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? 2'b11 : c + 2'b01;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? 2'b00 : c - 2'b01;
    endfunction

    assign unused_bits_s = ^{EM_target[1:0], EM_branch_target[1:0], EM_PC[1:0]};

    assign PCPlus4 = PC + 32'd4;

    // Lookup for the current fetch address and for the resolving branch.
    always_comb begin
        idx_s        = PC[BTB_BITS+1:2];
        tag_s        = PC[31:BTB_BITS+2];
        hit_s        = valid_r[idx_s] && (tag_r[idx_s] == tag_s);
        branch_taken = hit_s && ctr_r[idx_s][1];
        upd_idx_s    = EM_PC[BTB_BITS+1:2];
        upd_tag_s    = EM_PC[31:BTB_BITS+2];
        upd_hit_s    = valid_r[upd_idx_s] && (tag_r[upd_idx_s] == upd_tag_s);
    end

    // Next-PC selection: redirect beats stall, stall beats prediction.
    always_comb begin
        next_pc_s = PCPlus4;
        if (EM_redirect) begin
            next_pc_s = {EM_target[31:2], 2'b00};
        end else if (!PCWrite) begin
            next_pc_s = PC;
        end else if (branch_taken) begin
            next_pc_s = target_r[idx_s];
        end else begin
            next_pc_s = PCPlus4;
        end
    end

    // PC register.
    always_ff @(posedge clk) begin
        if (rst) begin
            PC <= RESET_PC;
        end else begin
            PC <= next_pc_s;
        end
    end

    // Table training; independent of stall and redirect, no write-through to lookup.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_r[i]    <= '0;
                target_r[i] <= 32'h0000_0000;
                ctr_r[i]    <= 2'b01;
            end
        end else if (EM_update) begin
            if (upd_hit_s) begin
                if (EM_taken) begin
                    ctr_r[upd_idx_s]    <= sat_inc(ctr_r[upd_idx_s]);
                    target_r[upd_idx_s] <= {EM_branch_target[31:2], 2'b00};
                end else begin
                    ctr_r[upd_idx_s] <= sat_dec(ctr_r[upd_idx_s]);
                end
            end else if (EM_taken) begin
                valid_r[upd_idx_s]  <= 1'b1;
                tag_r[upd_idx_s]    <= upd_tag_s;
                target_r[upd_idx_s] <= {EM_branch_target[31:2], 2'b00};
                ctr_r[upd_idx_s]    <= 2'b10;
            end else begin
                valid_r <= valid_r;
            end
        end else begin
            valid_r <= valid_r;
        end
    end

endmodule

// File: tb/tb_fetch_pc_predictor.sv
// Directed, table-driven bench for fetch_pc_predictor (BTB_BITS=4, RESET_PC=0).
module tb_fetch_pc_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic        PCWrite;
    logic        EM_redirect;
    logic [31:0] EM_target;
    logic        EM_update;
    logic [31:0] EM_PC;
    logic        EM_taken;
    logic [31:0] EM_branch_target;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        branch_taken;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        pcw;
        logic        rd;
        logic [31:0] tgt;
        logic        up;
        logic [31:0] empc;
        logic        tk;
        logic [31:0] btgt;
        logic [31:0] exp_pc;
        logic        exp_bt;
    } vec_t;

    vec_t vq[$];

    fetch_pc_predictor #(.BTB_BITS(4), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .PCWrite(PCWrite), .EM_redirect(EM_redirect),
        .EM_target(EM_target), .EM_update(EM_update), .EM_PC(EM_PC),
        .EM_taken(EM_taken), .EM_branch_target(EM_branch_target),
        .PC(PC), .PCPlus4(PCPlus4), .branch_taken(branch_taken)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic v(input logic pcw, input logic rd, input logic [31:0] tgt,
                     input logic up, input logic [31:0] empc, input logic tk,
                     input logic [31:0] btgt, input logic [31:0] epc, input logic ebt);
        vec_t e;
        e.pcw = pcw; e.rd = rd; e.tgt = tgt; e.up = up; e.empc = empc;
        e.tk = tk; e.btgt = btgt; e.exp_pc = epc; e.exp_bt = ebt;
        vq.push_back(e);
    endtask

    task automatic drive(input logic pcw, input logic rd, input logic [31:0] tgt,
                         input logic up, input logic [31:0] empc, input logic tk,
                         input logic [31:0] btgt);
        PCWrite = pcw; EM_redirect = rd; EM_target = tgt;
        EM_update = up; EM_PC = empc; EM_taken = tk; EM_branch_target = btgt;
    endtask

    task automatic check_state(input string tag, input logic [31:0] epc, input logic ebt);
        check({tag, ".PC"}, PC, epc);
        check({tag, ".PCPlus4"}, PCPlus4, epc + 32'd4);
        check({tag, ".bt"}, {31'd0, branch_taken}, {31'd0, ebt});
    endtask

    initial begin
        // Sequential scenario: each row is the state seen before the edge that applies it.
        v(1'b1,1'b0,32'h0,    1'b0,32'h0, 1'b0,32'h0,  32'h0000_0000,1'b0); // 0
        v(1'b1,1'b0,32'h0,    1'b0,32'h0, 1'b0,32'h0,  32'h0000_0004,1'b0);
        v(1'b1,1'b0,32'h0,    1'b0,32'h0, 1'b0,32'h0,  32'h0000_0008,1'b0);
        v(1'b1,1'b0,32'h0,    1'b0,32'h0, 1'b0,32'h0,  32'h0000_000C,1'b0);
        v(1'b0,1'b0,32'h0,    1'b0,32'h0, 1'b0,32'h0,  32'h0000_0010,1'b0); // stall
        v(1'b0,1'b0,32'h0,    1'b0,32'h0, 1'b0,32'h0,  32'h0000_0010,1'b0);
        v(1'b0,1'b0,32'h0,    1'b0,32'h0, 1'b0,32'h0,  32'h0000_0010,1'b0);
        v(1'b0,1'b1,32'h203,  1'b0,32'h0, 1'b0,32'h0,  32'h0000_0010,1'b0); // redirect over stall
        v(1'b1,1'b1,32'h38,   1'b1,32'h40,1'b1,32'h100,32'h0000_0200,1'b0); // allocate 0x40
        v(1'b1,1'b0,32'h0,    1'b0,32'h0, 1'b0,32'h0,  32'h0000_0038,1'b0);
        v(1'b1,1'b0,32'h0,    1'b0,32'h0, 1'b0,32'h0,  32'h0000_003C,1'b0); // 10
        v(1'b1,1'b0,32'h0,    1'b0,32'h0, 1'b0,32'h0,  32'h0000_0040,1'b1);
        v(1'b0,1'b0,32'h0,    1'b1,32'h40,1'b1,32'h100,32'h0000_0100,1'b0); // ctr 10->11
        v(1'b0,1'b0,32'h0,    1'b1,32'h40,1'b1,32'h100,32'h0000_0100,1'b0); // saturate
        v(1'b0,1'b0,32'h0,    1'b1,32'h40,1'b1,32'h100,32'h0000_0100,1'b0);
        v(1'b0,1'b0,32'h0,    1'b1,32'h40,1'b0,32'h0,  32'h0000_0100,1'b0); // 11->10
        v(1'b1,1'b1,32'h40,   1'b0,32'h0, 1'b0,32'h0,  32'h0000_0100,1'b0);
        v(1'b1,1'b0,32'h0,    1'b1,32'h40,1'b0,32'h0,  32'h0000_0040,1'b1); // 10->01, old value seen
        v(1'b1,1'b1,32'h40,   1'b0,32'h0, 1'b0,32'h0,  32'h0000_0100,1'b0);
        v(1'b1,1'b0,32'h0,    1'b0,32'h0, 1'b0,32'h0,  32'h0000_0040,1'b0); // weak NT
        v(1'b1,1'b1,32'h40,   1'b1,32'h80,1'b1,32'h300,32'h0000_0044,1'b0); // 20: evict with 0x80
        v(1'b1,1'b0,32'h0,    1'b0,32'h0, 1'b0,32'h0,  32'h0000_0040,1'b0);
        v(1'b1,1'b1,32'h80,   1'b0,32'h0, 1'b0,32'h0,  32'h0000_0044,1'b0);
        v(1'b1,1'b0,32'h0,    1'b0,32'h0, 1'b0,32'h0,  32'h0000_0080,1'b1);
        v(1'b1,1'b1,32'h40,   1'b0,32'h0, 1'b0,32'h0,  32'h0000_0300,1'b0);
        v(1'b1,1'b0,32'h0,    1'b1,32'h40,1'b1,32'h500,32'h0000_0040,1'b0); // same-cycle allocate
        v(1'b1,1'b1,32'h40,   1'b0,32'h0, 1'b0,32'h0,  32'h0000_0044,1'b0);
        v(1'b1,1'b0,32'h0,    1'b0,32'h0, 1'b0,32'h0,  32'h0000_0040,1'b1);
        v(1'b1,1'b1,32'hFFFF_FFFC,1'b0,32'h0,1'b0,32'h0,32'h0000_0500,1'b0);
        v(1'b1,1'b0,32'h0,    1'b0,32'h0, 1'b0,32'h0,  32'hFFFF_FFFC,1'b0); // wrap
        v(1'b1,1'b1,32'h40,   1'b1,32'h40,1'b1,32'h603,32'h0000_0000,1'b0); // 30: retarget on hit
        v(1'b1,1'b0,32'h0,    1'b0,32'h0, 1'b0,32'h0,  32'h0000_0040,1'b1);
        v(1'b1,1'b0,32'h0,    1'b0,32'h0, 1'b0,32'h0,  32'h0000_0600,1'b0);

        rst = 1'b1;
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_state("reset", 32'h0000_0000, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            if (i != 0) @(negedge clk);
            drive(vq[i].pcw, vq[i].rd, vq[i].tgt, vq[i].up, vq[i].empc, vq[i].tk, vq[i].btgt);
            #1;
            check_state($sformatf("row%0d", i), vq[i].exp_pc, vq[i].exp_bt);
        end

        // Mid-stream reset beats redirect and training and clears the table.
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 1'b1, 32'h700, 1'b1, 32'h40, 1'b1, 32'h900);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        check_state("midrst", 32'h0000_0000, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        check_state("cleared", 32'h0000_0040, 1'b0);
        @(negedge clk);
        #1;
        check_state("after_clear", 32'h0000_0044, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
